seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring integer divider. It is the initiator side of the ALU op interface:
//   it drives one subtract step per clock (op 3'b110 convention, a - b) and keeps quotient
//   and remainder state. It sits beside the combinational ALU in the execute stage and
//   handles DIV/REM, with a valid/ready handshake on both the command and result sides.
// PARAMETERS
//   WIDTH   32   operand, quotient and remainder width in bits (>= 4)
// PORTS
//   clk          in   1      single clock; all state updates on the rising edge
//   rst          in   1      asynchronous, active-high reset
//   in_valid     in   1      command valid
//   in_ready     out  1      command accepted when in_valid & in_ready on a clk edge
//   dividend     in   WIDTH  numerator, sampled at acceptance
//   divisor      in   WIDTH  denominator, sampled at acceptance
//   out_valid    out  1      result valid; held until out_ready
//   out_ready    in   1      result consumed when out_valid & out_ready on a clk edge
//   quotient     out  WIDTH  result quotient; stable while out_valid
//   remainder    out  WIDTH  result remainder; stable while out_valid
//   div_by_zero  out  1      set with the result when divisor was 0
// BEHAVIOUR
// - Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
// - FSM states:
//     IDLE  in_ready=1. On accept with divisor!=0: go to BUSY, cnt=WIDTH, load the operands.
//           On accept with divisor==0: go to DONE next edge with quotient=all ones,
//           remainder=dividend, div_by_zero=1.
//     BUSY  in_ready=0. Each edge performs one restoring step:
//           rem' = {rem[WIDTH-2:0], q[WIDTH-1]}; diff = rem' - divisor (WIDTH+1 bits);
//           if diff is non-negative, rem=diff and shift in q bit 1, else rem=rem' and shift in 0.
//           cnt decrements; on the edge where cnt reaches 0, go to DONE.
//     DONE  out_valid=1, in_ready=0. On out_ready: go to IDLE. Outputs hold until then.
// - Latency: out_valid rises on the WIDTH-th rising edge after the acceptance edge.
//   For divide-by-zero it rises on the 1st edge.
// - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor (unsigned).
// - Backpressure: while out_ready=0 in DONE, all outputs are frozen and no new command is
//   accepted. There is no overlap: a new command is accepted one cycle after the result leaves.
// - Simultaneous events: in_valid is ignored outside IDLE. The step arithmetic is WIDTH+1 bits
//   wide so the MSB borrow is never lost.
// - Reset mid-operation (BUSY or DONE): abort immediately (async), return to reset values.
//   The in-flight result is discarded.
// - quotient/remainder keep their last value in IDLE; consumers qualify them with out_valid.
// CONFIGURATION
// - SEQ_DIVIDER_SIGNED_EN defined:
//     Adds input port is_signed (1 bit, sampled at acceptance).
//     When is_signed=1, operands are two's complement. Magnitudes are divided; the quotient
//     sign is the XOR of the operand signs, and the remainder takes the dividend's sign
//     (truncation toward zero). Sign fix-up is done combinationally at load and output,
//     so latency is unchanged.
//     Overflow case (most negative value / -1): quotient=most negative value, remainder=0.
//     Signed divide-by-zero: quotient=-1 (all ones), remainder=dividend.
// - Macro undefined: the is_signed port is absent and operation is unsigned only.
// STRUCTURE
// - Package seq_div_pkg holds:
//     the state typedef {IDLE, BUSY, DONE};
//     localparams ALU_OP_AND=3'b000, ALU_OP_OR=3'b001, ALU_OP_ADD=3'b010,
//       ALU_OP_SUB=3'b110, ALU_OP_SLT=3'b111;
//     the counter width localparam $clog2(WIDTH+1).
// - Sub-module div_step (combinational): one restoring step.
//     Inputs: rem, q, divisor. Outputs: rem_next, q_next.
//     Built from the ripple subtractor plus a select mux.
// - Top level contains the FSM, the counter, the operand registers and the sign fix-up logic.
// TESTING
// 1. dividend=100, divisor=7 -> out_valid 32 edges after accept; quotient=14, remainder=2,
//    div_by_zero=0.
// 2. dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
//    dividend=5, divisor=9 -> quotient=0, remainder=5.
// 3. dividend=42, divisor=0 -> out_valid on the 1st edge; quotient=0xFFFFFFFF, remainder=42,
//    div_by_zero=1.
// 4. Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> outputs frozen,
//    in_ready=0, no second accept.
// 5. Assert rst 5 cycles into BUSY -> out_valid=0 and in_ready=1 immediately.
//    A new 100/7 command then completes correctly.
// 6. (SEQ_DIVIDER_SIGNED_EN) -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1;
//    0x80000000/-1 -> q=0x80000000, r=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Operation codes of the neighbouring ALU; each divider step is an ALU_OP_SUB (a - b).
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int CNT_WIDTH       = $clog2(DEFAULT_WIDTH + 1);

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Command/result handshake bundle of seq_divider.
// SEQ_DIVIDER_SIGNED_EN adds the is_signed command field.
interface seq_divider_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             is_signed;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
`ifdef SEQ_DIVIDER_SIGNED_EN
        output is_signed,
`endif
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef SEQ_DIVIDER_SIGNED_EN
        input  is_signed,
`endif
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift, ripple subtract, select.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH-1:0] diff;
    logic             carry;

    always_comb begin
        // NOTE: blocking assignments here: carry is a scratch variable rippled bit by bit within one evaluation.
        shifted = {rem, q[WIDTH-1]};
        sub_b   = ~{1'b0, divisor};
        carry   = 1'b1;
        diff    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = shifted[i] ^ sub_b[i] ^ carry;
            carry   = (shifted[i] & sub_b[i]) | (carry & (shifted[i] ^ sub_b[i]));
        end
        // Carry out of the extra top bit means no borrow: shifted >= divisor.
        carry = (shifted[WIDTH] & sub_b[WIDTH]) | (carry & (shifted[WIDTH] ^ sub_b[WIDTH]));

        if (carry) begin
            rem_next = diff;
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operation selected by is_signed.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, q_r, dvs_r;
    logic [WIDTH-1:0] rem_next, q_next;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic             in_ready_r, out_valid_r, dbz_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             neg_q, neg_r;
    logic             neg_q_in, neg_r_in;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .divisor  (dvs_r),
        .rem_next (rem_next),
        .q_next   (q_next)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic a_neg, b_neg;
    assign a_neg    = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg    = bus.is_signed & bus.divisor[WIDTH-1];
    assign a_mag    = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag    = b_neg ? -bus.divisor  : bus.divisor;
    assign neg_q_in = a_neg ^ b_neg;
    assign neg_r_in = a_neg;
`else
    assign a_mag    = bus.dividend;
    assign b_mag    = bus.divisor;
    assign neg_q_in = 1'b0;
    assign neg_r_in = 1'b0;
`endif

    // Truncation toward zero: quotient sign from both operands, remainder follows the dividend.
    assign q_fix = neg_q ? -q_next   : q_next;
    assign r_fix = neg_r ? -rem_next : rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            q_r         <= '0;
            dvs_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(WIDTH);
                            rem_r <= '0;
                            q_r   <= a_mag;
                            dvs_r <= b_mag;
                            neg_q <= neg_q_in;
                            neg_r <= neg_r_in;
                        end
                    end
                end
                BUSY: begin
                    rem_r <= rem_next;
                    q_r   <= q_next;
                    cnt   <= cnt - 1'b1;
                    // The last step's result is committed on the same edge that enters DONE.
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        quotient_r  <= q_fix;
                        remainder_r <= r_fix;
                        dbz_r       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic division, truncating toward zero in signed mode.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
        logic signed [W-1:0] sa, sb;
        sa  = a;
        sb  = b;
        dbz = (b == 0);
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Issue one command; optionally hold out_ready low for hold cycles while pulsing in_valid.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input int hold, input string tag);
        logic [W-1:0] eq, er;
        logic         edbz;
        int           lat;
        ref_div(a, b, sgn, eq, er, edbz);
        @(negedge clk);
        wait_ready(tag);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.is_signed = sgn;
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus.out_valid !== 1'b1 && lat < 100);
        check({tag, ".latency"}, lat, (b == 0) ? 32'd1 : W);
        check({tag, ".quotient"}, bus.quotient, eq);
        check({tag, ".remainder"}, bus.remainder, er);
        check({tag, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.dividend = $urandom;
            bus.divisor  = $urandom_range(1, 50);
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
            check({tag, ".hold_q"}, bus.quotient, eq);
            check({tag, ".hold_r"}, bus.remainder, er);
        end

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".consumed"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
        if (hold > 0) begin
            @(posedge clk);
            #1;
            check({tag, ".no_second"}, {31'd0, bus.out_valid}, 32'd0);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.quotient", bus.quotient, 32'd0);
        check("rst.remainder", bus.remainder, 32'd0);
        check("rst.dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, 0, "d100_7");
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, "dmax_1");
        do_div(32'd5, 32'd9, 1'b0, 0, "d5_9");
        do_div(32'd42, 32'd0, 1'b0, 0, "d42_0");
        do_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, "dbig_div");
        do_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, "dnear_max");
        do_div(32'd1000, 32'd3, 1'b0, 10, "backpressure");
        do_div(32'd77, 32'd0, 1'b0, 4, "bp_dbz");

        // Abort mid-BUSY: reset is asynchronous, so the effect is visible before any edge.
        @(negedge clk);
        wait_ready("abort");
        bus.in_valid = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy.in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        do_div(32'd100, 32'd7, 1'b0, 0, "after_abort");

        // Abort while a result waits in DONE.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_done.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_done.quotient", bus.quotient, 32'd0);
        check("abort_done.dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 8 == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            do_div(a, b, 1'b0, 0, $sformatf("rand%0d", i));
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_div(-32'sd7, 32'd2, 1'b1, 0, "s_m7_2");
        do_div(32'd7, -32'sd2, 1'b1, 0, "s_7_m2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        do_div(-32'sd42, 32'd0, 1'b1, 0, "s_dbz");
        do_div(-32'sd100, -32'sd7, 1'b1, 0, "s_m100_m7");
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd3;
            if (i[0]) b = -b;
            do_div(a, b, 1'b1, 0, $sformatf("srand%0d", i));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
